// File: rtl/mult_req_responder_2p.sv
// mult_req_responder_2p
//   Responder for the multiplier request/response stream used by barret_mod_pipe.
//   Two initiator request ports share one pipelined DAT_BITS x DAT_BITS unsigned
//   multiplier. Each product is routed back to the port that issued the request,
//   and the request tag is returned with it unchanged.
//
// Ports
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_reqN_dat/ctl/val    request N: {b,a} operands and tag; o_reqN_rdy accepts
//   o_rspN_dat/ctl/val    response N: full 2*DAT_BITS product and tag; i_rspN_rdy consumes
//   o_busy                high while any pipeline stage holds a valid entry
//
// Notes
//   - The whole pipe stalls when the head entry cannot leave. This blocks the
//     other port too (head-of-line blocking), which keeps global acceptance order.
//   - Response outputs come straight from the last stage registers.
//   - o_reqN_rdy is combinational on the request valids and the head port's rsp rdy.
module mult_req_responder_2p #(
    parameter int DAT_BITS = 256,
    parameter int CTL_BITS = 8,
    parameter int LAT      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic [2*DAT_BITS-1:0] i_req0_dat,
    input  logic [CTL_BITS-1:0]   i_req0_ctl,
    input  logic                  i_req0_val,
    output logic                  o_req0_rdy,

    input  logic [2*DAT_BITS-1:0] i_req1_dat,
    input  logic [CTL_BITS-1:0]   i_req1_ctl,
    input  logic                  i_req1_val,
    output logic                  o_req1_rdy,

    output logic [2*DAT_BITS-1:0] o_rsp0_dat,
    output logic [CTL_BITS-1:0]   o_rsp0_ctl,
    output logic                  o_rsp0_val,
    input  logic                  i_rsp0_rdy,

    output logic [2*DAT_BITS-1:0] o_rsp1_dat,
    output logic [CTL_BITS-1:0]   o_rsp1_ctl,
    output logic                  o_rsp1_val,
    input  logic                  i_rsp1_rdy,

    output logic                  o_busy
);
    localparam int PW  = 2 * DAT_BITS;
    localparam int LST = LAT - 1;

    // Per-stage state: valid, originating port, tag, product
    logic [LAT-1:0]               val_q, val_d;
    logic [LAT-1:0]               pid_q, pid_d;
    logic [LAT-1:0][CTL_BITS-1:0] ctl_q, ctl_d;
    logic [LAT-1:0][PW-1:0]       dat_q, dat_d;

    // Port granted by the most recent handshake; resets to 1 so port0 wins the first tie
    logic last_grant_q, last_grant_d;

    logic                stall;
    logic                gnt0, gnt1;
    logic                hs0, hs1;
    logic [DAT_BITS-1:0] op_a, op_b;
    logic [PW-1:0]       prod;

    // Arbitration and stall
    always_comb begin
        stall = val_q[LST] & ~(pid_q[LST] ? i_rsp1_rdy : i_rsp0_rdy);
        // On a tie the port that did not win last time is granted
        gnt0  = i_req0_val & (~i_req1_val | last_grant_q);
        gnt1  = i_req1_val & (~i_req0_val | ~last_grant_q);
        hs0   = ~i_rst & ~stall & gnt0;
        hs1   = ~i_rst & ~stall & gnt1;
    end

    assign o_req0_rdy = hs0;
    assign o_req1_rdy = hs1;

    // Operand select and multiply. The full product is formed at the stage-0
    // input; later stages only delay it, so register retiming can spread the
    // multiplier across the LAT stages.
    always_comb begin
        op_a = gnt1 ? i_req1_dat[DAT_BITS-1:0]  : i_req0_dat[DAT_BITS-1:0];
        op_b = gnt1 ? i_req1_dat[PW-1:DAT_BITS] : i_req0_dat[PW-1:DAT_BITS];
        prod = {{DAT_BITS{1'b0}}, op_a} * {{DAT_BITS{1'b0}}, op_b};
    end

    // Next state of the pipe: on stall every stage holds, bubbles included
    always_comb begin
        val_d        = val_q;
        pid_d        = pid_q;
        ctl_d        = ctl_q;
        dat_d        = dat_q;
        last_grant_d = last_grant_q;
        if (!stall) begin
            for (int k = 1; k < LAT; k++) begin
                val_d[k] = val_q[k-1];
                pid_d[k] = pid_q[k-1];
                ctl_d[k] = ctl_q[k-1];
                dat_d[k] = dat_q[k-1];
            end
            val_d[0] = hs0 | hs1;
            if (hs0 | hs1) begin
                pid_d[0]     = hs1;
                ctl_d[0]     = hs1 ? i_req1_ctl : i_req0_ctl;
                dat_d[0]     = prod;
                last_grant_d = hs1;
            end
        end
    end

    // Control state is reset; in-flight entries are discarded
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            val_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            val_q        <= val_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Datapath needs no reset; it is qualified by val_q
    always_ff @(posedge i_clk) begin
        pid_q <= pid_d;
        ctl_q <= ctl_d;
        dat_q <= dat_d;
    end

    // Responses: data/tag fanned out to both ports, valid only to the owner
    assign o_rsp0_dat = dat_q[LST];
    assign o_rsp0_ctl = ctl_q[LST];
    assign o_rsp0_val = val_q[LST] & ~pid_q[LST];
    assign o_rsp1_dat = dat_q[LST];
    assign o_rsp1_ctl = ctl_q[LST];
    assign o_rsp1_val = val_q[LST] & pid_q[LST];

    assign o_busy = |val_q;

endmodule

// File: tb/tb_mult_req_responder_2p.sv
// Self-checking bench for mult_req_responder_2p (DAT_BITS=16, CTL_BITS=8, LAT=3).
// A monitor pushes expected {ctl, a*b} per port (and the global port order) on
// every request handshake and pops/compares on every response handshake.
module tb_mult_req_responder_2p;
    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int LAT  = 3;
    localparam int PW   = 2 * DW;
    localparam int NREQ = 10000;

    logic          i_clk, i_rst;
    logic [PW-1:0] i_req0_dat, i_req1_dat;
    logic [CW-1:0] i_req0_ctl, i_req1_ctl;
    logic          i_req0_val, i_req1_val;
    logic          o_req0_rdy, o_req1_rdy;
    logic [PW-1:0] o_rsp0_dat, o_rsp1_dat;
    logic [CW-1:0] o_rsp0_ctl, o_rsp1_ctl;
    logic          o_rsp0_val, o_rsp1_val;
    logic          i_rsp0_rdy, i_rsp1_rdy;
    logic          o_busy;

    mult_req_responder_2p #(.DAT_BITS(DW), .CTL_BITS(CW), .LAT(LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_dat(i_req0_dat), .i_req0_ctl(i_req0_ctl), .i_req0_val(i_req0_val), .o_req0_rdy(o_req0_rdy),
        .i_req1_dat(i_req1_dat), .i_req1_ctl(i_req1_ctl), .i_req1_val(i_req1_val), .o_req1_rdy(o_req1_rdy),
        .o_rsp0_dat(o_rsp0_dat), .o_rsp0_ctl(o_rsp0_ctl), .o_rsp0_val(o_rsp0_val), .i_rsp0_rdy(i_rsp0_rdy),
        .o_rsp1_dat(o_rsp1_dat), .o_rsp1_ctl(o_rsp1_ctl), .o_rsp1_val(o_rsp1_val), .i_rsp1_rdy(i_rsp1_rdy),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [CW+PW-1:0] exp_q0[$];
    logic [CW+PW-1:0] exp_q1[$];
    logic             ord_q[$];
    logic [CW+PW-1:0] e;
    logic             p;
    logic [PW-1:0]    d0;
    logic [PW-1:0]    pexp;
    logic             done0, done1;
    int               sent, cyc;
    logic             pend0, pend1;

    task automatic test_reset();
        i_req0_val = 1'b1;
        i_req1_val = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_req0_rdy, o_req1_rdy} !== 2'b00) begin
            errors++; $display("FAIL reset_req_rdy got=%b exp=00", {o_req0_rdy, o_req1_rdy});
        end
        checks++;
        if ({o_rsp0_val, o_rsp1_val, o_busy} !== 3'b000) begin
            errors++; $display("FAIL reset_rsp_val_busy got=%b exp=000", {o_rsp0_val, o_rsp1_val, o_busy});
        end
        @(posedge i_clk); #1;
        i_req0_val = 1'b0;
        i_req1_val = 1'b0;
        i_rst      = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy got=%b exp=0", o_busy);
        end
    endtask

    // Both ports valid every cycle: grants alternate starting with port0, one rsp per cycle
    task automatic test_alternate();
        i_rsp0_rdy = 1'b1;
        i_rsp1_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge i_clk); #1;
            i_req0_val = 1'b1; i_req0_dat = PW'($urandom()); i_req0_ctl = CW'(2 * k);
            i_req1_val = 1'b1; i_req1_dat = PW'($urandom()); i_req1_ctl = CW'(2 * k + 1);
            @(negedge i_clk);
            checks++;
            if ({o_req0_rdy, o_req1_rdy} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL alt_grant cyc=%0d got=%b exp=%b", k, {o_req0_rdy, o_req1_rdy},
                                   (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (k >= LAT) begin
                checks++;
                if ({o_rsp0_val, o_rsp1_val} !== (((k - LAT) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL alt_rsp_port cyc=%0d got=%b", k, {o_rsp0_val, o_rsp1_val});
                end
            end
        end
        @(posedge i_clk); #1;
        i_req0_val = 1'b0; i_req1_val = 1'b0;
        for (int i = 0; i < 40 && o_busy; i++) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++; $display("FAIL alt_drain busy=%b q0=%0d q1=%0d exp=0/0/0", o_busy, exp_q0.size(), exp_q1.size());
        end
    endtask

    // Single port0 request: response exactly LAT cycles later on port0 only
    task automatic test_single();
        i_rsp0_rdy = 1'b1;
        i_rsp1_rdy = 1'b1;
        @(posedge i_clk); #1;
        i_req0_val = 1'b1; i_req0_dat = 32'hFFFF_FFFF; i_req0_ctl = 8'h5A;
        @(negedge i_clk);
        checks++;
        if (o_req0_rdy !== 1'b1) begin
            errors++; $display("FAIL single_rdy got=%b exp=1", o_req0_rdy);
        end
        @(posedge i_clk); #1;
        i_req0_val = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_rsp0_val !== (i == LAT) || o_rsp1_val !== 1'b0) begin
                errors++; $display("FAIL single_latency cyc=+%0d got=%b%b exp=%b0", i, o_rsp0_val, o_rsp1_val, (i == LAT));
            end
            if (i == 1) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++; $display("FAIL single_busy got=%b exp=1", o_busy);
                end
            end
        end
        checks++;
        if (o_rsp0_dat !== 32'hFFFE_0001 || o_rsp0_ctl !== 8'h5A) begin
            errors++; $display("FAIL single_data got=%h/%h exp=fffe0001/5a", o_rsp0_dat, o_rsp0_ctl);
        end
        @(negedge i_clk);
    endtask

    // Port0 head blocked for 5 cycles: pipe frozen, nothing accepted, nothing lost
    task automatic test_stall();
        i_rsp0_rdy = 1'b0;
        i_rsp1_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            i_req0_val = 1'b1; i_req0_dat = PW'($urandom()); i_req0_ctl = CW'(8'h30 + k);
            if (k == 0) d0 = i_req0_dat;
            @(negedge i_clk);
            checks++;
            if (o_req0_rdy !== 1'b1) begin
                errors++; $display("FAIL stall_fill_rdy k=%0d got=%b exp=1", k, o_req0_rdy);
            end
        end
        pexp = 32'(d0[DW-1:0]) * 32'(d0[PW-1:DW]);
        @(posedge i_clk); #1;
        i_req0_dat = PW'($urandom()); i_req0_ctl = 8'h33;
        i_req1_val = 1'b1; i_req1_dat = PW'($urandom()); i_req1_ctl = 8'hC0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_rsp0_val !== 1'b1 || o_rsp0_dat !== pexp || o_rsp0_ctl !== 8'h30) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h exp=1/%h/30", i, o_rsp0_val, o_rsp0_dat, o_rsp0_ctl, pexp);
            end
            checks++;
            if ({o_req0_rdy, o_req1_rdy} !== 2'b00) begin
                errors++; $display("FAIL stall_req_rdy cyc=%0d got=%b exp=00", i, {o_req0_rdy, o_req1_rdy});
            end
        end
        @(posedge i_clk); #1;
        i_rsp0_rdy = 1'b1;
        done0 = 1'b0; done1 = 1'b0;
        for (int i = 0; i < 20 && !(done0 && done1); i++) begin
            @(negedge i_clk);
            if (o_req0_rdy) done0 = 1'b1;
            if (o_req1_rdy) done1 = 1'b1;
            @(posedge i_clk); #1;
            if (done0) i_req0_val = 1'b0;
            if (done1) i_req1_val = 1'b0;
        end
        checks++;
        if (!(done0 && done1)) begin
            errors++; $display("FAIL stall_release_timeout got=%b%b exp=11", done0, done1);
        end
        for (int i = 0; i < 40 && o_busy; i++) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++; $display("FAIL stall_drain busy=%b q0=%0d q1=%0d exp=0/0/0", o_busy, exp_q0.size(), exp_q1.size());
        end
    endtask

    // Port1 head blocked: port0 requests are held off too; order kept on release
    task automatic test_hol();
        i_rsp0_rdy = 1'b1;
        i_rsp1_rdy = 1'b0;
        @(posedge i_clk); #1;
        i_req1_val = 1'b1; i_req1_dat = PW'($urandom()); i_req1_ctl = 8'hA1;
        @(negedge i_clk);
        checks++;
        if (o_req1_rdy !== 1'b1) begin
            errors++; $display("FAIL hol_req1_rdy got=%b exp=1", o_req1_rdy);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge i_clk); #1;
            i_req1_val = 1'b0;
            i_req0_val = 1'b1; i_req0_dat = PW'($urandom()); i_req0_ctl = CW'(8'h40 + k);
            @(negedge i_clk);
        end
        @(posedge i_clk); #1;
        i_req0_dat = PW'($urandom()); i_req0_ctl = 8'h42;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_req0_rdy !== 1'b0 || o_rsp1_val !== 1'b1 || o_rsp0_val !== 1'b0) begin
                errors++; $display("FAIL hol_block cyc=%0d rdy0=%b rsp1=%b rsp0=%b exp=0/1/0", i, o_req0_rdy, o_rsp1_val, o_rsp0_val);
            end
        end
        @(posedge i_clk); #1;
        i_rsp1_rdy = 1'b1;
        done0 = 1'b0;
        for (int i = 0; i < 20 && !done0; i++) begin
            @(negedge i_clk);
            if (o_req0_rdy) done0 = 1'b1;
            @(posedge i_clk); #1;
            if (done0) i_req0_val = 1'b0;
        end
        checks++;
        if (!done0) begin
            errors++; $display("FAIL hol_release_timeout got=0 exp=1");
        end
        for (int i = 0; i < 40 && o_busy; i++) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++; $display("FAIL hol_drain busy=%b q0=%0d q1=%0d exp=0/0/0", o_busy, exp_q0.size(), exp_q1.size());
        end
    endtask

    // Reset with entries in flight: outputs drop at once, nothing comes out afterwards
    task automatic test_reset_mid();
        i_rsp0_rdy = 1'b1;
        i_rsp1_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            i_req0_val = 1'b1; i_req0_dat = PW'($urandom()); i_req0_ctl = CW'(8'h70 + k);
            @(negedge i_clk);
        end
        @(posedge i_clk); #1;
        i_req0_val = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_inflight got=%b exp=1", o_busy);
        end
        #1 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_rsp0_val, o_rsp1_val, o_busy, o_req0_rdy, o_req1_rdy} !== 5'b0) begin
            errors++; $display("FAIL rstmid_async got=%b exp=00000", {o_rsp0_val, o_rsp1_val, o_busy, o_req0_rdy, o_req1_rdy});
        end
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checks++;
            if ({o_rsp0_val, o_rsp1_val, o_busy} !== 3'b000) begin
                errors++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=000", i, {o_rsp0_val, o_rsp1_val, o_busy});
            end
        end
    endtask

    // Random operands, valids and response readies on both ports
    task automatic test_random();
        sent = 0; cyc = 0; pend0 = 1'b0; pend1 = 1'b0;
        while (sent < NREQ && cyc < 60000) begin
            @(posedge i_clk); #1;
            cyc++;
            if (!pend0 && $urandom_range(3) != 0) begin
                pend0 = 1'b1; i_req0_dat = PW'($urandom()); i_req0_ctl = CW'($urandom());
            end
            if (!pend1 && $urandom_range(3) != 0) begin
                pend1 = 1'b1; i_req1_dat = PW'($urandom()); i_req1_ctl = CW'($urandom());
            end
            i_req0_val = pend0;
            i_req1_val = pend1;
            i_rsp0_rdy = ($urandom_range(3) != 0);
            i_rsp1_rdy = ($urandom_range(3) != 0);
            @(negedge i_clk);
            if (pend0 && o_req0_rdy) begin pend0 = 1'b0; sent++; end
            if (pend1 && o_req1_rdy) begin pend1 = 1'b0; sent++; end
        end
        @(posedge i_clk); #1;
        i_req0_val = 1'b0; i_req1_val = 1'b0;
        i_rsp0_rdy = 1'b1; i_rsp1_rdy = 1'b1;
        checks++;
        if (sent < NREQ) begin
            errors++; $display("FAIL random_timeout sent=%0d exp>=%0d", sent, NREQ);
        end
        for (int i = 0; i < 40 && o_busy; i++) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++; $display("FAIL random_drain busy=%b q0=%0d q1=%0d exp=0/0/0", o_busy, exp_q0.size(), exp_q1.size());
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_req0_val = 1'b0; i_req0_dat = '0; i_req0_ctl = '0;
        i_req1_val = 1'b0; i_req1_dat = '0; i_req1_ctl = '0;
        i_rsp0_rdy = 1'b1; i_rsp1_rdy = 1'b1;

        // Scoreboard monitor
        fork
            forever begin
                @(negedge i_clk);
                if (i_rst) begin
                    exp_q0.delete(); exp_q1.delete(); ord_q.delete();
                end else begin
                    if (i_req0_val && o_req0_rdy) begin
                        exp_q0.push_back({i_req0_ctl, 32'(i_req0_dat[DW-1:0]) * 32'(i_req0_dat[PW-1:DW])});
                        ord_q.push_back(1'b0);
                    end
                    if (i_req1_val && o_req1_rdy) begin
                        exp_q1.push_back({i_req1_ctl, 32'(i_req1_dat[DW-1:0]) * 32'(i_req1_dat[PW-1:DW])});
                        ord_q.push_back(1'b1);
                    end
                    if (o_rsp0_val && o_rsp1_val) begin
                        checks++; errors++; $display("FAIL rsp_both_valid got=11 exp=one-hot");
                    end
                    if (o_rsp0_val && i_rsp0_rdy) begin
                        checks++;
                        if (exp_q0.size() == 0 || ord_q.size() == 0) begin
                            errors++; $display("FAIL rsp0_unexpected got=%h/%h exp=none", o_rsp0_ctl, o_rsp0_dat);
                        end else begin
                            e = exp_q0.pop_front(); p = ord_q.pop_front();
                            if ({o_rsp0_ctl, o_rsp0_dat} !== e || p !== 1'b0) begin
                                errors++; $display("FAIL rsp0_data got=%h/%h exp=%h/%h order_port=%b", o_rsp0_ctl, o_rsp0_dat, e[CW+PW-1:PW], e[PW-1:0], p);
                            end
                        end
                    end
                    if (o_rsp1_val && i_rsp1_rdy) begin
                        checks++;
                        if (exp_q1.size() == 0 || ord_q.size() == 0) begin
                            errors++; $display("FAIL rsp1_unexpected got=%h/%h exp=none", o_rsp1_ctl, o_rsp1_dat);
                        end else begin
                            e = exp_q1.pop_front(); p = ord_q.pop_front();
                            if ({o_rsp1_ctl, o_rsp1_dat} !== e || p !== 1'b1) begin
                                errors++; $display("FAIL rsp1_data got=%h/%h exp=%h/%h order_port=%b", o_rsp1_ctl, o_rsp1_dat, e[CW+PW-1:PW], e[PW-1:0], p);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_alternate();
        test_single();
        test_stall();
        test_hol();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
